// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: instruction-fetch sequencer.
// Computes nextPC for the external PC register, issues one fetch at a time to
// instruction memory over valid/ready, buffers one returned word toward decode,
// and applies execute redirects (flushing the buffer and dropping in-flight data).
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   PC / nextPC                     current PC in, combinational next PC out
//   imem_req_valid/addr/ready       fetch request handshake (addr == PC)
//   imem_rsp_valid/data             fetch response, one per accepted request
//   instr_valid/instr/instr_pc      registered one-entry buffer to decode
//   instr_ready                     decode consumes the buffer
//   redirect_valid/redirect_target  PC redirect from execute
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] nextPC,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            load_c;
  logic            flush_c;
  logic [XLEN-1:0] target_aligned_c;

  // Redirect targets are word aligned by clearing the two low bits.
  assign target_aligned_c = redirect_target & ~XLEN'(3);

  // A response is captured only in WAIT when no redirect kills it.
  assign load_c  = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  // Redirects are ignored while booting; otherwise they flush the buffer.
  assign flush_c = redirect_valid && (state_q != ST_BOOT);

  assign imem_req_addr = PC;

  // Next-state, request and next-PC decode.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    nextPC         = PC;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // Request only when the buffer can take the word and no redirect is pending.
        imem_req_valid = (!instr_valid || instr_ready) && !redirect_valid;
        if (imem_req_valid && imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (state_q == ST_BOOT) begin
      nextPC = RESET_PC;
    end else if (redirect_valid) begin
      nextPC = target_aligned_c;
    end else if (load_c) begin
      nextPC = PC + XLEN'(4);
    end
  end

  // State register and decode buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state_q <= state_d;
      if (flush_c) begin
        instr_valid <= 1'b0;
      end else if (load_c) begin
        instr_valid <= 1'b1;
        instr       <= imem_rsp_data;
        instr_pc    <= PC;
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
